// File: rtl/sub_clk_cfg_ctrl.sv
// Sequences sub-clock frequency requests through one shared 32-step restoring divider.
// Fixed 66-cycle request-to-done latency; ready only when idle, both counts committed together.
module sub_clk_cfg_ctrl #(
  parameter logic [31:0] CLK_FEQ     = 32'd50000000,
  parameter logic [31:0] RST_FEQ_CNT = 32'd50000,
  parameter logic [31:0] RST_SCL_CNT = 32'd50000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [15:0] cfg_feq,
  input  logic [15:0] cfg_scl,
  output logic [31:0] sub_count_max,
  output logic [31:0] subsub_count_max,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIV_FEQ = 2'd1,
    DIV_SCL = 2'd2,
    COMMIT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] feq_q, feq_d;
  logic [15:0] scl_q, scl_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] feq_cnt_q, feq_cnt_d;
  logic [31:0] scl_cnt_q, scl_cnt_d;
  logic [31:0] sub_q, sub_d;
  logic [31:0] subsub_q, subsub_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  // One restoring-division step, shared by both DIV states.
  logic [31:0] divisor;
  logic [4:0]  bit_idx;
  logic [32:0] rem_sh;
  logic        take;
  logic [32:0] rem_step;
  logic [31:0] quo_step;

  always_comb begin
    divisor  = (state_q == DIV_SCL) ? {16'd0, scl_q} : {16'd0, feq_q};
    bit_idx  = 5'd31 - cnt_q[4:0];
    rem_sh   = {rem_q[31:0], CLK_FEQ[bit_idx]};
    take     = (rem_sh >= {1'b0, divisor});
    rem_step = take ? (rem_sh - {1'b0, divisor}) : rem_sh;
    quo_step = {quo_q[30:0], take};
  end

  always_comb begin
    state_d   = state_q;
    feq_d     = feq_q;
    scl_d     = scl_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    feq_cnt_d = feq_cnt_q;
    scl_cnt_d = scl_cnt_q;
    sub_d     = sub_q;
    subsub_d  = subsub_q;
    done_d    = 1'b0;
    err_d     = err_q;

    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          feq_d   = cfg_feq;
          scl_d   = cfg_scl;
          err_d   = 1'b0;
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = '0;
          state_d = DIV_FEQ;
        end
      end
      DIV_FEQ, DIV_SCL: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          // Partial state is cleared so the next pass starts from a zero remainder.
          rem_d = '0;
          quo_d = '0;
          cnt_d = '0;
          if (state_q == DIV_FEQ) begin
            feq_cnt_d = quo_step;
            state_d   = DIV_SCL;
          end else begin
            scl_cnt_d = quo_step;
            state_d   = COMMIT;
          end
        end
      end
      COMMIT: begin
        sub_d    = feq_cnt_q;
        subsub_d = scl_cnt_q;
        done_d   = 1'b1;
        err_d    = (feq_q == 16'd0) || (scl_q == 16'd0);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      feq_q     <= '0;
      scl_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      feq_cnt_q <= '0;
      scl_cnt_q <= '0;
      sub_q     <= RST_FEQ_CNT;
      subsub_q  <= RST_SCL_CNT;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      feq_q     <= feq_d;
      scl_q     <= scl_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      feq_cnt_q <= feq_cnt_d;
      scl_cnt_q <= scl_cnt_d;
      sub_q     <= sub_d;
      subsub_q  <= subsub_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign cfg_ready        = (state_q == IDLE);
  assign busy             = ~cfg_ready;
  assign sub_count_max    = sub_q;
  assign subsub_count_max = subsub_q;
  assign cfg_done         = done_q;
  assign cfg_err          = err_q;

endmodule

// File: tb/tb_sub_clk_cfg_ctrl.sv
// Bench for sub_clk_cfg_ctrl: vector table, hand-written corner sequences and a
// randomized phase checked against an arithmetic floor-division model.
module tb_sub_clk_cfg_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [15:0] cfg_feq = '0;
  logic [15:0] cfg_scl = '0;
  logic        cfg_ready, cfg_done, cfg_err, busy;
  logic [31:0] sub_count_max, subsub_count_max;

  sub_clk_cfg_ctrl dut (
    .clk              (clk),
    .rstn             (rstn),
    .cfg_valid        (cfg_valid),
    .cfg_ready        (cfg_ready),
    .cfg_feq          (cfg_feq),
    .cfg_scl          (cfg_scl),
    .sub_count_max    (sub_count_max),
    .subsub_count_max (subsub_count_max),
    .cfg_done         (cfg_done),
    .cfg_err          (cfg_err),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: floor(CLK_FEQ / d), all ones for a zero divisor.
  function automatic logic [31:0] model(input logic [15:0] d);
    int unsigned q;
    if (d == 16'd0) return 32'hFFFF_FFFF;
    q = 32'd50000000 / {16'd0, d};
    return q;
  endfunction

  // Counts may only move in a cycle where cfg_done is high.
  logic        mon_en = 1'b0;
  logic [31:0] prev_sub = '0, prev_ssub = '0;
  always @(negedge clk) begin
    if (mon_en && (sub_count_max !== prev_sub || subsub_count_max !== prev_ssub)) begin
      tests++;
      if (cfg_done !== 1'b1) begin
        fails++;
        $display("FAIL atomic_update: counts became %0d/%0d with cfg_done=%b, required cfg_done=1",
                 sub_count_max, subsub_count_max, cfg_done);
      end
    end
    prev_sub  = sub_count_max;
    prev_ssub = subsub_count_max;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Full job: accept in cycle 0, check busy window, result and done pulse in cycle 66.
  task automatic run_job(input logic [15:0] f, input logic [15:0] s, input logic [31:0] es,
                         input logic [31:0] ess, input logic ee, input logic pulse10);
    int bad_busy = 0;
    int bad_done = 0;
    @(negedge clk);
    check("ready_before_accept", {31'd0, cfg_ready}, 32'd1);
    cfg_valid = 1'b1;
    cfg_feq   = f;
    cfg_scl   = s;
    for (int k = 1; k <= 65; k++) begin
      @(negedge clk);
      if (k == 1) check("err_cleared_on_accept", {31'd0, cfg_err}, 32'd0);
      if (pulse10 && k == 10) begin
        cfg_valid = 1'b1;
        cfg_feq   = 16'd5;
        cfg_scl   = 16'd5;
      end else begin
        cfg_valid = 1'b0;
        cfg_feq   = 16'($urandom);
        cfg_scl   = 16'($urandom);
      end
      if (busy !== 1'b1 || cfg_ready !== 1'b0) bad_busy++;
      if (cfg_done !== 1'b0) bad_done++;
    end
    check("busy_cycles_1_to_65", bad_busy, 0);
    check("no_done_before_66", bad_done, 0);
    @(negedge clk);
    cfg_valid = 1'b0;
    check("done_cycle66", {31'd0, cfg_done}, 32'd1);
    check("ready_cycle66", {31'd0, cfg_ready}, 32'd1);
    check("sub_count_max", sub_count_max, es);
    check("subsub_count_max", subsub_count_max, ess);
    check("cfg_err", {31'd0, cfg_err}, {31'd0, ee});
    @(negedge clk);
    check("done_single_cycle", {31'd0, cfg_done}, 32'd0);
  endtask

  typedef struct {
    logic [15:0] feq;
    logic [15:0] scl;
    logic [31:0] sub;
    logic [31:0] ssub;
    logic        err;
    logic        pulse10;
  } vec_t;

  vec_t vt[8];

  initial begin
    int          acc[$];
    int          dcyc[$];
    logic [15:0] af[$];
    logic [15:0] as[$];
    logic [31:0] dsub[$];
    logic [31:0] dssub[$];
    int          extra_done;
    int          waited;
    logic [15:0] rf, rs;

    vt[0] = '{16'd1000,  16'd400,   32'd50000,        32'd125000,       1'b0, 1'b0};
    vt[1] = '{16'd3,     16'd65535, 32'd16666666,     32'd762,          1'b0, 1'b0};
    vt[2] = '{16'd1,     16'd1,     32'd50000000,     32'd50000000,     1'b0, 1'b0};
    vt[3] = '{16'd0,     16'd500,   32'hFFFF_FFFF,    32'd100000,       1'b1, 1'b0};
    vt[4] = '{16'd1000,  16'd1000,  32'd50000,        32'd50000,        1'b0, 1'b1};
    vt[5] = '{16'd7,     16'd13,    32'd7142857,      32'd3846153,      1'b0, 1'b0};
    vt[6] = '{16'd65535, 16'd2,     32'd762,          32'd25000000,     1'b0, 1'b1};
    vt[7] = '{16'd0,     16'd0,     32'hFFFF_FFFF,    32'hFFFF_FFFF,    1'b1, 1'b0};

    // Reset state.
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, cfg_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, cfg_done}, 32'd0);
    check("rst_err", {31'd0, cfg_err}, 32'd0);
    check("rst_sub", sub_count_max, 32'd50000);
    check("rst_subsub", subsub_count_max, 32'd50000);
    rstn = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    foreach (vt[i]) run_job(vt[i].feq, vt[i].scl, vt[i].sub, vt[i].ssub, vt[i].err, vt[i].pulse10);
    // A pulse during the job must not have started another one.
    repeat (3) @(negedge clk);
    check("no_spurious_accept", {31'd0, busy}, 32'd0);

    // Reset in cycle 40 of a 1000/400 job.
    mon_en = 1'b0;
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_feq   = 16'd1000;
    cfg_scl   = 16'd400;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      cfg_valid = 1'b0;
    end
    rstn = 1'b0;
    @(negedge clk);
    check("midrst_sub", sub_count_max, 32'd50000);
    check("midrst_subsub", subsub_count_max, 32'd50000);
    check("midrst_done", {31'd0, cfg_done}, 32'd0);
    check("midrst_ready", {31'd0, cfg_ready}, 32'd1);
    rstn = 1'b1;
    extra_done = 0;
    repeat (80) begin
      @(negedge clk);
      if (cfg_done) extra_done++;
    end
    check("midrst_no_commit", extra_done, 0);
    mon_en = 1'b1;

    // cfg_valid held high with fresh data every cycle.
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (cfg_done) begin
        dcyc.push_back(c);
        dsub.push_back(sub_count_max);
        dssub.push_back(subsub_count_max);
      end
      cfg_valid = 1'b1;
      cfg_feq   = 16'($urandom_range(1, 65535));
      cfg_scl   = 16'($urandom_range(1, 65535));
      if (cfg_ready) begin
        acc.push_back(c);
        af.push_back(cfg_feq);
        as.push_back(cfg_scl);
      end
    end
    check("hold_accept_count", acc.size(), 4);
    check("hold_done_count", dcyc.size(), 3);
    for (int i = 0; i < acc.size() && i < 4; i++) check("hold_accept_cycle", acc[i], i * 66);
    for (int i = 0; i < dcyc.size() && i < 3 && i < af.size(); i++) begin
      check("hold_done_cycle", dcyc[i], (i + 1) * 66);
      check("hold_sub", dsub[i], model(af[i]));
      check("hold_subsub", dssub[i], model(as[i]));
    end
    waited = 0;
    @(negedge clk);
    cfg_valid = 1'b0;
    while (!cfg_done && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("hold_last_done_in_time", {31'd0, cfg_done}, 32'd1);
    if (af.size() == 4) begin
      check("hold_last_sub", sub_count_max, model(af[3]));
      check("hold_last_subsub", subsub_count_max, model(as[3]));
    end

    // Randomized requests against the reference model.
    for (int n = 0; n < 20; n++) begin
      rf = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      rs = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 300));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_job(rf, rs, model(rf), model(rs), (rf == 16'd0) || (rs == 16'd0),
              1'($urandom_range(0, 1)));
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
